// File: rtl/spi_segment_master.sv
// spi_segment_master: SPI mode-0 initiator, MSB first, one byte per chip-select
// frame. Frame timing in clk cycles after the accepting edge, with D = CLK_DIV:
// SETUP D, SHIFT 16*D, HOLD D, GAP D.
// Optional build macro SPI_MASTER_MISO_CAPTURE_EN adds the miso input and the
// rx_data readback register. The transmit path is the same in both builds.
module spi_segment_master #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_done,
    output logic                  sclk,
    output logic                  mosi,
`ifdef SPI_MASTER_MISO_CAPTURE_EN
    input  logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
`endif
    output logic                  cs_n
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    state_e                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [3:0]            half_q, half_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  tx_done_q, tx_done_d;
    logic                  div_end;
    logic                  half_end;
    logic                  accept;

    assign div_end  = (div_q == DIV_W'(CLK_DIV - 1));
    assign half_end = (half_q == 4'd15);
    assign accept   = tx_valid && (state_q == IDLE);

    // State register; reset overrides a simultaneous acceptance.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: each timed state ends when the divider reaches CLK_DIV-1.
    always_comb begin
        // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (div_end) state_d = SHIFT;
            SHIFT:   if (div_end && half_end) state_d = HOLD;
            HOLD:    if (div_end) state_d = GAP;
            GAP:     if (div_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered SPI pins, counters and shifter.
    always_comb begin
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        shreg_d   = shreg_q;
        half_d    = half_q;
        tx_done_d = 1'b0;
        div_d     = (state_q == IDLE || div_end) ? '0 : div_q + DIV_W'(1);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = tx_data;
                    cs_n_d  = 1'b0;
                    mosi_d  = tx_data[DATA_WIDTH-1];
                    half_d  = '0;
                end
            end
            SETUP: begin
                // First rising SCLK edge opens half-period 0.
                if (div_end) begin
                    sclk_d = 1'b1;
                    half_d = '0;
                end
            end
            SHIFT: begin
                if (div_end && !half_end) begin
                    half_d = half_q + 4'd1;
                    sclk_d = ~sclk_q;
                    // Falling edge advances mosi, except the 8th fall (entering half 15).
                    if (sclk_q && half_q != 4'd14) begin
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                        mosi_d  = shreg_q[DATA_WIDTH-2];
                    end
                end
            end
            HOLD: begin
                if (div_end) begin
                    cs_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    tx_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; a reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            half_q    <= '0;
            shreg_q   <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            half_q    <= half_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign tx_done  = tx_done_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

`ifdef SPI_MASTER_MISO_CAPTURE_EN
    logic [DATA_WIDTH-1:0] rx_shreg_q, rx_shreg_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rise_evt;

    // Receive logic: sample miso on every rising SCLK edge, publish with tx_done.
    always_comb begin
        rise_evt   = (state_q == SETUP && div_end) ||
                     (state_q == SHIFT && div_end && !half_end && !sclk_q);
        rx_shreg_d = rise_evt ? {rx_shreg_q[DATA_WIDTH-2:0], miso} : rx_shreg_q;
        rx_data_d  = (state_q == HOLD && div_end) ? rx_shreg_q : rx_data_q;
    end

    // Receive registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shreg_q <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_shreg_q <= rx_shreg_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign rx_data = rx_data_q;
`endif

endmodule

// File: tb/tb_spi_segment_master.sv
// Bench for spi_segment_master: one instance with CLK_DIV=4 (index 0) and one
// with CLK_DIV=1 (index 1). Outputs are sampled on the falling clk edge and
// compared cycle by cycle against a waveform model derived from frame timing.
module tb_spi_segment_master;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0][7:0] tx_data;
    logic [1:0]      tx_valid;
    logic [1:0]      tx_ready;
    logic [1:0]      tx_done;
    logic [1:0]      sclk;
    logic [1:0]      mosi;
    logic [1:0]      cs_n;
`ifdef SPI_MASTER_MISO_CAPTURE_EN
    logic [1:0]      miso;
    logic [1:0][7:0] rx_data;
    logic [7:0]      slave_byte;
    logic [1:0][7:0] exp_rx;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_segment_master #(.CLK_DIV(4), .DATA_WIDTH(8)) u_dut_div4 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx_done(tx_done[0]), .sclk(sclk[0]), .mosi(mosi[0]),
`ifdef SPI_MASTER_MISO_CAPTURE_EN
        .miso(miso[0]), .rx_data(rx_data[0]),
`endif
        .cs_n(cs_n[0])
    );

    spi_segment_master #(.CLK_DIV(1), .DATA_WIDTH(8)) u_dut_div1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx_done(tx_done[1]), .sclk(sclk[1]), .mosi(mosi[1]),
`ifdef SPI_MASTER_MISO_CAPTURE_EN
        .miso(miso[1]), .rx_data(rx_data[1]),
`endif
        .cs_n(cs_n[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int div_of(input int sel);
        return (sel == 0) ? 4 : 1;
    endfunction

    // Observed pins packed as {cs_n, sclk, mosi, tx_done, tx_ready}.
    function automatic logic [4:0] outs(input int sel);
        return {cs_n[sel], sclk[sel], mosi[sel], tx_done[sel], tx_ready[sel]};
    endfunction

    // Expected pins t edges after the accepting edge, from the frame timeline.
    function automatic logic [4:0] model_out(input logic [7:0] b, input int t, input int d);
        int h;
        int idx;
        if (t < d) return {1'b0, 1'b0, b[7], 2'b00};
        if (t < 17 * d) begin
            h   = (t - d) / d;
            idx = 7 - (h + 1) / 2;
            if (idx < 0) idx = 0;
            return {1'b0, (h % 2 == 0), b[idx], 2'b00};
        end
        if (t < 18 * d) return {1'b0, 1'b0, b[0], 2'b00};
        if (t < 19 * d) return {1'b1, 1'b0, 1'b0, (t == 18 * d), 1'b0};
        return 5'b10001;
    endfunction

    // Send one frame, or two with tx_valid held, and check every cycle.
    task automatic run_frames(input int sel, input logic [7:0] b0, input logic [7:0] b1,
                              input int nf, input int exp_done, input int exp_ready);
        int         d;
        int         p;
        int         last;
        int         f;
        int         rises;
        int         falls;
        int         hi_run;
        int         ready_t;
        int         done_t[$];
        logic [7:0] got[$];
        logic [7:0] bytes[2];
        logic [7:0] cap;
        logic       prev_sclk;
        logic       prev_cs;
`ifdef SPI_MASTER_MISO_CAPTURE_EN
        int         sidx;
`endif
        d = div_of(sel);
        p = 19 * d + 1;
        last = (nf - 1) * p + 19 * d;
        bytes[0] = b0;
        bytes[1] = b1;
        cap = '0;
        rises = 0;
        falls = 0;
        hi_run = 0;
        ready_t = -1;
        prev_sclk = 1'b0;
        prev_cs = 1'b1;
`ifdef SPI_MASTER_MISO_CAPTURE_EN
        sidx = 7;
`endif
        check("pre_ready", tx_ready[sel], 1'b1);
        tx_data[sel]  = b0;
        tx_valid[sel] = 1'b1;
        for (int t = 0; t <= last; t++) begin
            @(negedge clk);
            f = (t >= p) ? 1 : 0;
            check($sformatf("wave_d%0d_t%0d", d, t), outs(sel), model_out(bytes[f], t - f * p, d));
            if (sclk[sel] && !prev_sclk && !cs_n[sel]) begin
                cap = {cap[6:0], mosi[sel]};
                rises++;
                if (rises % 8 == 0) got.push_back(cap);
            end
            if (tx_done[sel]) done_t.push_back(t);
            if (tx_ready[sel] && ready_t < 0) ready_t = t;
            if (!cs_n[sel] && prev_cs) begin
                falls++;
                if (falls > 1) check("deselect_min", (hi_run >= d), 1'b1);
            end
            if (cs_n[sel]) hi_run++;
            else hi_run = 0;
`ifdef SPI_MASTER_MISO_CAPTURE_EN
            if (t - f * p == 18 * d - 1) check("rx_hold", rx_data[sel], exp_rx[sel]);
            if (tx_done[sel]) begin
                exp_rx[sel] = slave_byte;
                check("rx_data", rx_data[sel], exp_rx[sel]);
            end
            if (!cs_n[sel] && prev_cs) begin
                sidx = 7;
                miso[sel] = slave_byte[7];
            end else if (!sclk[sel] && prev_sclk) begin
                sidx--;
                miso[sel] = (sidx >= 0) ? slave_byte[sidx] : 1'b0;
            end
`endif
            prev_sclk = sclk[sel];
            prev_cs   = cs_n[sel];
            if (t == 0) begin
                if (nf == 2) begin
                    tx_data[sel] = b1;
                end else begin
                    tx_valid[sel] = 1'b0;
                    tx_data[sel]  = ~b0;
                end
            end
            if (nf == 2 && t == p) begin
                tx_valid[sel] = 1'b0;
                tx_data[sel]  = ~b1;
            end
        end
        check("byte_count", got.size(), nf);
        for (int i = 0; i < got.size() && i < nf; i++) check("spi_byte", got[i], bytes[i]);
        check("done_count", done_t.size(), nf);
        if (done_t.size() > 0) check("done_latency", done_t[0], exp_done);
        check("ready_latency", ready_t, exp_ready);
        check("cs_frames", falls, nf);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         exp_done;
        int         exp_ready;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int sel;
        int nf;
        int rises;
        logic prev;

        vecs[0] = '{0, 8'hA5, 72, 76};
        vecs[1] = '{1, 8'h80, 18, 19};
        vecs[2] = '{1, 8'h01, 18, 19};
        vecs[3] = '{0, 8'h00, 72, 76};
        vecs[4] = '{1, 8'hFF, 18, 19};

        rst = 1'b1;
        tx_valid = '0;
        tx_data = '0;
`ifdef SPI_MASTER_MISO_CAPTURE_EN
        miso = '0;
        slave_byte = 8'h00;
        exp_rx = '0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state held while idle.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) check("idle", outs(s), 5'b10001);
        end
`ifdef SPI_MASTER_MISO_CAPTURE_EN
        check("rx_reset0", rx_data[0], 8'h00);
        check("rx_reset1", rx_data[1], 8'h00);
`endif

        // Directed single-frame vectors.
        for (int i = 0; i < 5; i++)
            run_frames(vecs[i].sel, vecs[i].data, 8'h00, 1, vecs[i].exp_done, vecs[i].exp_ready);

        // Back-to-back with tx_valid held.
        run_frames(0, 8'h3F, 8'h06, 2, 72, 76);
        run_frames(1, 8'h80, 8'h01, 2, 18, 19);

`ifdef SPI_MASTER_MISO_CAPTURE_EN
        slave_byte = 8'hC3;
        run_frames(0, 8'h55, 8'h00, 1, 72, 76);
        slave_byte = 8'h3A;
        run_frames(1, 8'h55, 8'h00, 1, 18, 19);
`endif

        // Randomised frames against the timeline model.
        for (int i = 0; i < 8; i++) begin
            sel = $urandom_range(0, 1);
            nf  = $urandom_range(1, 2);
`ifdef SPI_MASTER_MISO_CAPTURE_EN
            slave_byte = 8'($urandom);
`endif
            run_frames(sel, 8'($urandom), 8'($urandom), nf, 18 * div_of(sel), 19 * div_of(sel));
        end

        // Reset mid-frame after the 3rd rising SCLK edge of 0xFF.
        tx_data[0] = 8'hFF;
        tx_valid[0] = 1'b1;
        rises = 0;
        prev = 1'b0;
        for (int c = 0; c < 200 && rises < 3; c++) begin
            @(negedge clk);
            if (c == 0) tx_valid[0] = 1'b0;
            if (sclk[0] && !prev) rises++;
            prev = sclk[0];
        end
        check("midrst_reached", rises, 3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", outs(0), 5'b10001);
        rst = 1'b0;
`ifdef SPI_MASTER_MISO_CAPTURE_EN
        exp_rx = '0;
        check("midrst_rx", rx_data[0], exp_rx[0]);
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("midrst_no_resume", outs(0), 5'b10001);
        end
        run_frames(0, 8'h12, 8'h00, 1, 72, 76);

        // rst and tx_valid together: rst wins, byte is dropped.
        rst = 1'b1;
        tx_valid[0] = 1'b1;
        tx_data[0] = 8'hAA;
        @(negedge clk);
        check("rst_vs_valid", outs(0), 5'b10001);
        rst = 1'b0;
        tx_valid[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_vs_valid_idle", outs(0), 5'b10001);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_segment_master.md
Name: spi_segment_master

Overview:
- SPI initiator (mode 0, MSB first) that serialises display bytes into a remote SPI segment controller, one byte per chip-select frame.
- Sits between on-chip display logic (a byte source with valid/ready) and the uio pins wired to the controller's SCLK/MOSI/CS_N inputs.
- It is the transmit end of the same link the segment controller receives on.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 1..255.
- DATA_WIDTH, 8, bits per frame; fixed at 8 for the segment protocol.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- tx_data  input  8  byte to send; latched on acceptance
- tx_valid  input  1  source has a byte
- tx_ready  output  1  block can accept a byte
- tx_done  output  1  one-cycle pulse when a frame completes
- sclk  output  1  SPI clock, idles low
- mosi  output  1  SPI data out
- cs_n  output  1  chip select, active-low

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values, effective on the first edge with rst=1, including mid-frame:
  - state=IDLE, sclk=0, cs_n=1, mosi=0, tx_done=0, tx_ready=1.
  - Shift register, bit counter and divider counter cleared.
  - A frame in progress is abandoned and never resumed.
- tx_ready is high only in IDLE. A byte is accepted on any edge with tx_valid && tx_ready. tx_data changes after acceptance are ignored.
- States:
  - IDLE: accepting edge latches tx_data, cs_n->0, mosi->tx_data[7], goes to SETUP with the divider cleared.
  - SETUP: CLK_DIV cycles with sclk=0 (CS-to-first-edge setup). Then SHIFT.
  - SHIFT: 16 half-periods of CLK_DIV cycles each.
    - sclk toggles at the start of every half-period: rise, fall, rise, ...
    - On each falling edge except the 8th, mosi advances to the next lower bit.
    - mosi is stable for a full half-period before every rising edge.
    - After the 8th falling edge, goes to HOLD.
  - HOLD: CLK_DIV cycles with sclk=0 and cs_n=0, mosi holding bit0. Then cs_n->1, mosi->0, tx_done=1 for exactly one cycle, goes to GAP.
  - GAP: CLK_DIV cycles with cs_n=1 (minimum deselect time). Then IDLE.
- Latency: tx_ready is low for exactly 19*CLK_DIV cycles after the accepting edge. tx_done is asserted on the edge 18*CLK_DIV cycles after acceptance.
- Back-to-back: if tx_valid is held high, the next byte is accepted on the first IDLE cycle. cs_n is always deasserted for at least CLK_DIV cycles between frames.
- Counters:
  - Divider counter width is clog2(CLK_DIV+1) and wraps to 0 at CLK_DIV-1.
  - 4-bit half-period counter runs 0..15. No other wrap-around exists.
- CLK_DIV=1: sclk = clk/2. Same state sequence, each state lasting 1 cycle.
- rst and tx_valid in the same cycle: rst wins and the byte is not accepted.

Optional Feature:
- Macro: SPI_MASTER_MISO_CAPTURE_EN.
- With the macro defined:
  - Adds input miso (1) and output rx_data (8).
  - miso is sampled into a receive shift register on each sclk rising edge, MSB first.
  - rx_data updates on the same edge tx_done asserts and holds until the next tx_done. It resets to 0x00.
  - This allows readback of the controller's status byte.
- Without the macro: the miso and rx_data ports do not exist and no receive logic is built. Transmit behaviour is identical in both builds.

Test Plan:
- Reset then idle: after rst for 2 cycles, check sclk=0, cs_n=1, mosi=0, tx_ready=1, tx_done=0, all held for 50 cycles with tx_valid=0.
- Single byte, CLK_DIV=4, tx_data=0xA5:
  - cs_n falls 1 cycle after acceptance.
  - A bench SPI mode-0 sampler captures 0xA5 on 8 rising edges.
  - sclk high/low each 4 cycles.
  - tx_done pulses once, 72 cycles after acceptance.
  - tx_ready returns after 76 cycles.
- Back-to-back, tx_valid held with 0x3F then 0x06:
  - Two separate cs_n frames.
  - cs_n high for at least 4 cycles between them.
  - Sampler sees 0x3F then 0x06.
  - Exactly two tx_done pulses.
- CLK_DIV=1 with tx_data=0x80, then 0x01:
  - sclk period is 2 cycles.
  - mosi is high only before the 1st (0x80) or 8th (0x01) rising edge.
  - tx_ready is low 19 cycles per frame.
- Reset mid-frame: assert rst after the 3rd sclk rise of 0xFF.
  - Next edge: cs_n=1, sclk=0, tx_ready=1, no tx_done.
  - A subsequent 0x12 transmits cleanly.
- SPI_MASTER_MISO_CAPTURE_EN build: bench drives 0xC3 on miso in mode 0 while sending 0x55.
  - rx_data=0xC3 on the tx_done edge.
  - mosi stream is still 0x55.
